// File: rtl/messenger_nt_if.sv
// messenger_nt_if: EU, network, context-channel and error-port signals of the message dispatcher
interface messenger_nt_if #(
    parameter int THREADS = 2
);
    logic [THREADS-1:0]    EUREQ;
    logic [64*THREADS-1:0] EUPARAM;
    logic [THREADS-1:0]    EUACK;
    logic                  NETREQ;
    logic [121:0]          NETPARAM;
    logic                  NETMSGRD;
    logic [THREADS-1:0]    ContextREQ;
    logic [96*THREADS-1:0] ContextMSG;
    logic [THREADS-1:0]    ContextRDY;
    logic [THREADS-1:0]    QFULL;
    logic                  ESTB;
    logic [63:0]           ERRC;

    modport master (
        output EUREQ, EUPARAM, NETREQ, NETPARAM, ContextRDY,
        input  EUACK, NETMSGRD, ContextREQ, ContextMSG, QFULL, ESTB, ERRC
    );

    modport slave (
        input  EUREQ, EUPARAM, NETREQ, NETPARAM, ContextRDY,
        output EUACK, NETMSGRD, ContextREQ, ContextMSG, QFULL, ESTB, ERRC
    );
endinterface

// File: rtl/messenger_nt.sv
// messenger_nt: per-thread queued dispatcher of EU/network messages to context channels with delivery timeout
module messenger_nt #(
    parameter int THREADS = 2,
    parameter int QDEPTH  = 4,
    parameter int TMO     = 1023
) (
    input logic           CLK,
    input logic           RESET,
    messenger_nt_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int TW = THREADS > 1 ? $clog2(THREADS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

    state_t             st     [THREADS];
    logic               req    [THREADS];
    logic               full_q [THREADS];
    logic [95:0]        msg    [THREADS];
    logic [THREADS-1:0] full, eu_wr, net_wr, gnt;
    logic [TW-1:0]      ts;
    logic               ts_ok, bad_req, bad_gnt, bad_done, any_gnt;
    logic [2:0]         gidx;
    logic [31:0]        err_idx;
    logic [95:0]        net_entry;

    assign ts        = THREADS > 1 ? bus.NETPARAM[80 +: TW] : '0;
    assign ts_ok     = int'(ts) < THREADS;
    assign net_entry = {bus.NETPARAM[63:32], 6'h02, bus.NETPARAM[121:120], bus.NETPARAM[119:96],
                        16'h0, bus.NETPARAM[79:64]};
    assign bad_req   = bus.NETREQ & ~ts_ok & ~bad_done;

    // Write gating uses the registered full flag; the shared error port goes to the lowest ERR thread
    always_comb begin
        full           = '0;
        eu_wr          = '0;
        net_wr         = '0;
        gnt            = '0;
        any_gnt        = 1'b0;
        gidx           = '0;
        err_idx        = '0;
        bus.ContextREQ = '0;
        bus.ContextMSG = '0;
        bus.QFULL      = '0;
        bus.EUACK      = '0;
        for (int i = 0; i < THREADS; i++) begin
            full[i]   = full_q[i];
            eu_wr[i]  = bus.EUREQ[i] & ~full[i];
            net_wr[i] = bus.NETREQ & ts_ok & (ts == TW'(i)) & ~bus.EUREQ[i] & ~full[i];
            if (st[i] == ERR && !any_gnt) begin
                gnt[i]  = 1'b1;
                any_gnt = 1'b1;
                gidx    = 3'(i);
                err_idx = msg[i][31:0];
            end
            bus.ContextREQ[i]         = req[i];
            bus.ContextMSG[96*i +: 96] = msg[i];
            bus.QFULL[i]              = full[i];
            bus.EUACK[i]              = eu_wr[i];
        end
        bad_gnt      = bad_req & ~any_gnt;
        bus.NETMSGRD = |net_wr;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.ESTB <= 1'b0;
            bus.ERRC <= '0;
            bad_done <= 1'b0;
        end else begin
            bus.ESTB <= any_gnt | bad_gnt;
            if (any_gnt)
                bus.ERRC <= {8'hE1, 5'h0, gidx, 16'h0, err_idx};
            else if (bad_gnt)
                bus.ERRC <= {8'hE2, 24'h0, bus.NETPARAM[95:64]};
            // one bad-target strobe per NETREQ assertion
            bad_done <= bus.NETREQ & (bad_done | bad_gnt);
        end
    end

    for (genvar t = 0; t < THREADS; t++) begin : g_th
        logic [95:0]   mem [QDEPTH];
        logic [95:0]   eu_entry;
        logic [AW-1:0] wp, rp;
        logic [AW:0]   cnt, cnt_n;
        logic [15:0]   tmr;
        logic          wr, pop;
        state_t        st_n;

        assign eu_entry = {bus.EUPARAM[64*t+32 +: 32], 8'h01, 24'h0, bus.EUPARAM[64*t +: 32]};
        assign wr       = eu_wr[t] | net_wr[t];
        assign pop      = (st[t] == REQ && bus.ContextRDY[t]) || (st[t] == ERR && gnt[t]);
        assign cnt_n    = cnt + (AW+1)'(wr) - (AW+1)'(pop);

        // RDY takes precedence over a timeout in the same cycle
        always_comb begin
            st_n = st[t];
            if (st[t] == IDLE)
                st_n = cnt != '0 ? REQ : IDLE;
            else if (st[t] == REQ)
                st_n = bus.ContextRDY[t] ? IDLE : (tmr == 16'(TMO) ? ERR : REQ);
            else
                st_n = gnt[t] ? IDLE : ERR;
        end

        always_ff @(posedge CLK) begin
            if (wr)
                mem[wp] <= eu_wr[t] ? eu_entry : net_entry;
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                st[t]     <= IDLE;
                wp        <= '0;
                rp        <= '0;
                cnt       <= '0;
                tmr       <= '0;
                req[t]    <= 1'b0;
                msg[t]    <= '0;
                full_q[t] <= 1'b0;
            end else begin
                st[t]     <= st_n;
                wp        <= wp + AW'(wr);
                rp        <= rp + AW'(pop);
                cnt       <= cnt_n;
                full_q[t] <= cnt_n == (AW+1)'(QDEPTH);
                tmr       <= st[t] == REQ ? tmr + 16'd1 : '0;
                req[t]    <= st_n == REQ;
                if (st[t] == IDLE && st_n == REQ)
                    msg[t] <= mem[rp];
            end
        end
    end
endmodule
